// File: rtl/load_buffer.sv
// load_buffer: small out-of-order load queue. Each entry waits for its base
// operand (directly or from the CDB), waits for store-ordering clearance,
// issues one word read to data memory, extracts the sub-word result and
// presents it to the CDB arbiter until granted.
module load_buffer #(
  parameter int LOAD_BUFFER_DEPTH = 3,
  parameter int ROB_SIZE          = 8,
  localparam int ROB_IX           = $clog2(ROB_SIZE) - 1
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  // issue port
  input  logic                                       valid_in,
  input  logic [ROB_IX:0]                            rob_ix_in,
  input  logic                                       base_ready_in,
  input  logic signed [31:0]                         base_value_in,
  input  logic [ROB_IX:0]                            base_tag_in,
  input  logic signed [31:0]                         imm_in,
  input  logic [2:0]                                 funct3_in,
  // common data bus snoop
  input  logic                                       cdb_valid_in,
  input  logic [ROB_IX:0]                            cdb_rob_ix_in,
  input  logic [31:0]                                cdb_value_in,
  // ordering, flush
  input  logic [LOAD_BUFFER_DEPTH-1:0]               can_load_in,
  input  logic                                       flush_in,
  // data memory
  input  logic                                       mem_ready_in,
  input  logic                                       mem_rvalid_in,
  input  logic [31:0]                                mem_rdata_in,
  // result arbitration
  input  logic                                       result_grant_in,
  output logic                                       ready_out,
  output logic [LOAD_BUFFER_DEPTH-1:0][ROB_IX:0]     lb_rob_arr_ix_out,
  output logic signed [LOAD_BUFFER_DEPTH-1:0][31:0]  lb_rob_arr_dest_out,
  output logic                                       mem_req_out,
  output logic [31:0]                                mem_addr_out,
  output logic                                       result_valid_out,
  output logic [ROB_IX:0]                            result_rob_ix_out,
  output logic [31:0]                                result_value_out
);

  typedef enum logic [2:0] {
    FREE       = 3'd0,
    WAIT_BASE  = 3'd1,
    WAIT_ORDER = 3'd2,
    ISSUED     = 3'd3,
    DONE       = 3'd4
  } entry_state_t;

  localparam int D = LOAD_BUFFER_DEPTH;

  // Extract the loaded value from a memory word by width and byte lane.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    load_extract = {{24{b[7]}}, b};
      3'd1:    load_extract = {{16{h[15]}}, h};
      3'd4:    load_extract = {24'd0, b};
      3'd5:    load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  // per-entry status seen by the shared selection logic
  logic [D-1:0]    free_vec;
  logic [D-1:0]    elig_vec;
  logic [D-1:0]    issued_vec;
  logic [D-1:0]    done_vec;
  logic [31:0]     addr_q   [D];
  logic [31:0]     value_q  [D];
  logic [ROB_IX:0] rob_ix_q [D];

  // one-hot selections
  logic [D-1:0] free_pick;
  logic [D-1:0] elig_pick;
  logic [D-1:0] alloc_oh;
  logic [D-1:0] issue_oh;
  logic [D-1:0] result_oh;
  logic         free_found;
  logic         elig_found;
  logic         done_found;

  // a flushed request is still in flight; its response must be dropped
  logic discard_reg;
  logic discard_next;

  // Lowest-index priority pick for allocation, memory issue and result.
  always_comb begin
    free_pick  = '0;
    elig_pick  = '0;
    result_oh  = '0;
    free_found = 1'b0;
    elig_found = 1'b0;
    done_found = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (free_vec[i] && !free_found) begin
        free_pick[i] = 1'b1;
        free_found   = 1'b1;
      end
      if (elig_vec[i] && !elig_found) begin
        elig_pick[i] = 1'b1;
        elig_found   = 1'b1;
      end
      if (done_vec[i] && !done_found) begin
        result_oh[i] = 1'b1;
        done_found   = 1'b1;
      end
    end
  end

  // Only one request may be outstanding, and none while a stale response is due.
  assign alloc_oh  = valid_in ? free_pick : '0;
  assign issue_oh  = (!(|issued_vec) && !discard_reg) ? elig_pick : '0;

  assign ready_out        = |free_vec;
  assign mem_req_out      = |issue_oh;
  assign result_valid_out = |result_oh;

  // Output muxes for the memory address and the presented result.
  always_comb begin
    mem_addr_out      = '0;
    result_rob_ix_out = '0;
    result_value_out  = '0;
    for (int i = 0; i < D; i++) begin
      if (issue_oh[i]) begin
        mem_addr_out = addr_q[i];
      end
      if (result_oh[i]) begin
        result_rob_ix_out = rob_ix_q[i];
        result_value_out  = value_q[i];
      end
    end
  end

  // Discard tracking: set when a flush orphans an in-flight request
  // (already issued, or being handshaken in the flush cycle itself).
  always_comb begin
    discard_next = discard_reg;
    if (discard_reg && mem_rvalid_in) begin
      discard_next = 1'b0;
    end
    if (flush_in && (((|issued_vec) && !mem_rvalid_in) ||
                     (mem_req_out && mem_ready_in))) begin
      discard_next = 1'b1;
    end
  end

  // Discard flag register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      discard_reg <= 1'b0;
    end else begin
      discard_reg <= discard_next;
    end
  end

  for (genvar gi = 0; gi < D; gi++) begin : g_entry
    entry_state_t    state_reg;
    entry_state_t    state_next;
    logic [ROB_IX:0] rob_ix_reg;
    logic [ROB_IX:0] rob_ix_next;
    logic [ROB_IX:0] base_tag_reg;
    logic [ROB_IX:0] base_tag_next;
    logic [31:0]     imm_reg;
    logic [31:0]     imm_next;
    logic [31:0]     addr_reg;
    logic [31:0]     addr_next;
    logic [31:0]     value_reg;
    logic [31:0]     value_next;
    logic [2:0]      funct3_reg;
    logic [2:0]      funct3_next;

    assign free_vec[gi]   = (state_reg == FREE);
    assign elig_vec[gi]   = (state_reg == WAIT_ORDER) && can_load_in[gi];
    assign issued_vec[gi] = (state_reg == ISSUED);
    assign done_vec[gi]   = (state_reg == DONE);
    assign addr_q[gi]     = addr_reg;
    assign value_q[gi]    = value_reg;
    assign rob_ix_q[gi]   = rob_ix_reg;

    assign lb_rob_arr_ix_out[gi]   = (state_reg == FREE) ? '0 : rob_ix_reg;
    assign lb_rob_arr_dest_out[gi] = ((state_reg == FREE) || (state_reg == WAIT_BASE))
                                     ? '0 : addr_reg;

    // Entry next-state: allocate, wake up, issue, capture, retire; flush wins.
    always_comb begin
      state_next    = state_reg;
      rob_ix_next   = rob_ix_reg;
      base_tag_next = base_tag_reg;
      imm_next      = imm_reg;
      addr_next     = addr_reg;
      value_next    = value_reg;
      funct3_next   = funct3_reg;
      if (flush_in) begin
        state_next = FREE;
      end else begin
        case (state_reg)
          FREE: begin
            if (alloc_oh[gi]) begin
              rob_ix_next   = rob_ix_in;
              base_tag_next = base_tag_in;
              imm_next      = imm_in;
              funct3_next   = funct3_in;
              if (base_ready_in) begin
                state_next = WAIT_ORDER;
                addr_next  = base_value_in + imm_in;
              end else if (cdb_valid_in && (cdb_rob_ix_in == base_tag_in)) begin
                state_next = WAIT_ORDER;
                addr_next  = cdb_value_in + imm_in;
              end else begin
                state_next = WAIT_BASE;
              end
            end
          end
          WAIT_BASE: begin
            if (cdb_valid_in && (cdb_rob_ix_in == base_tag_reg)) begin
              state_next = WAIT_ORDER;
              addr_next  = cdb_value_in + imm_reg;
            end
          end
          WAIT_ORDER: begin
            if (issue_oh[gi] && mem_ready_in) begin
              state_next = ISSUED;
            end
          end
          ISSUED: begin
            if (mem_rvalid_in && !discard_reg) begin
              state_next = DONE;
              value_next = load_extract(funct3_reg, addr_reg[1:0], mem_rdata_in);
            end
          end
          DONE: begin
            if (result_oh[gi] && result_grant_in) begin
              state_next = FREE;
            end
          end
          default: state_next = FREE;
        endcase
      end
    end

    // Entry state and payload registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        state_reg    <= FREE;
        rob_ix_reg   <= '0;
        base_tag_reg <= '0;
        imm_reg      <= '0;
        addr_reg     <= '0;
        value_reg    <= '0;
        funct3_reg   <= '0;
      end else begin
        state_reg    <= state_next;
        rob_ix_reg   <= rob_ix_next;
        base_tag_reg <= base_tag_next;
        imm_reg      <= imm_next;
        addr_reg     <= addr_next;
        value_reg    <= value_next;
        funct3_reg   <= funct3_next;
      end
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// tb_load_buffer: directed scoreboard bench for load_buffer.
module tb_load_buffer;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              valid_in;
  logic [2:0]        rob_ix_in;
  logic              base_ready_in;
  logic signed [31:0] base_value_in;
  logic [2:0]        base_tag_in;
  logic signed [31:0] imm_in;
  logic [2:0]        funct3_in;
  logic              cdb_valid_in;
  logic [2:0]        cdb_rob_ix_in;
  logic [31:0]       cdb_value_in;
  logic [2:0]        can_load_in;
  logic              flush_in;
  logic              mem_ready_in;
  logic              mem_rvalid_in;
  logic [31:0]       mem_rdata_in;
  logic              result_grant_in;
  logic              ready_out;
  logic [2:0][2:0]   lb_rob_arr_ix_out;
  logic signed [2:0][31:0] lb_rob_arr_dest_out;
  logic              mem_req_out;
  logic [31:0]       mem_addr_out;
  logic              result_valid_out;
  logic [2:0]        result_rob_ix_out;
  logic [31:0]       result_value_out;

  typedef struct {
    logic [2:0]  ix;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  load_buffer #(.LOAD_BUFFER_DEPTH(3), .ROB_SIZE(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .valid_in(valid_in), .rob_ix_in(rob_ix_in),
    .base_ready_in(base_ready_in), .base_value_in(base_value_in),
    .base_tag_in(base_tag_in), .imm_in(imm_in), .funct3_in(funct3_in),
    .cdb_valid_in(cdb_valid_in), .cdb_rob_ix_in(cdb_rob_ix_in),
    .cdb_value_in(cdb_value_in), .can_load_in(can_load_in),
    .flush_in(flush_in), .mem_ready_in(mem_ready_in),
    .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
    .result_grant_in(result_grant_in), .ready_out(ready_out),
    .lb_rob_arr_ix_out(lb_rob_arr_ix_out),
    .lb_rob_arr_dest_out(lb_rob_arr_dest_out),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .result_valid_out(result_valid_out),
    .result_rob_ix_out(result_rob_ix_out),
    .result_value_out(result_value_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_load(input logic [2:0] tag, input logic rdy, input logic [31:0] base,
                          input logic [2:0] btag, input logic [31:0] imm, input logic [2:0] f3);
    valid_in      = 1'b1;
    rob_ix_in     = tag;
    base_ready_in = rdy;
    base_value_in = base;
    base_tag_in   = btag;
    imm_in        = imm;
    funct3_in     = f3;
  endtask

  // Clear ordering, handshake, return rdata, and record the expected result.
  task automatic finish_issue(input string tag, input logic [31:0] exp_addr,
                              input logic [2:0] ix, input logic [31:0] rdata,
                              input logic [31:0] exp_val);
    can_load_in  = 3'b111;
    mem_ready_in = 1'b1;
    #1;
    chk({tag, "_req"}, mem_req_out, 1);
    chk({tag, "_addr"}, mem_addr_out, exp_addr);
    cyc();
    mem_ready_in = 1'b0;
    chk({tag, "_req_after_issue"}, mem_req_out, 0);
    sb_q.push_back('{ix: ix, val: exp_val});
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = rdata;
    cyc();
    mem_rvalid_in = 1'b0;
    #1;
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, check hold.
  task automatic wait_result();
    exp_t e;
    int   n;
    n = 0;
    while (result_valid_out !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("result_valid", result_valid_out, 1);
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 32'(sb_q.size()), 1);
    end else begin
      e = sb_q.pop_front();
      chk("result_ix", result_rob_ix_out, e.ix);
      chk("result_value", result_value_out, e.val);
      cyc();
      chk("result_hold_ix", result_rob_ix_out, e.ix);
      chk("result_hold_value", result_value_out, e.val);
    end
  endtask

  task automatic drain_result();
    wait_result();
    result_grant_in = 1'b1;
    cyc();
    result_grant_in = 1'b0;
  endtask

  task automatic load_once(input string tag, input logic [2:0] ix, input logic [31:0] base,
                           input logic [31:0] imm, input logic [2:0] f3,
                           input logic [31:0] exp_addr, input logic [31:0] rdata,
                           input logic [31:0] exp_val);
    set_load(ix, 1'b1, base, 3'd0, imm, f3);
    cyc();
    valid_in = 1'b0;
    finish_issue(tag, exp_addr, ix, rdata, exp_val);
    drain_result();
  endtask

  initial begin
    rst_in = 1'b1;
    valid_in = 0; rob_ix_in = 0; base_ready_in = 0; base_value_in = 0;
    base_tag_in = 0; imm_in = 0; funct3_in = 0; cdb_valid_in = 0;
    cdb_rob_ix_in = 0; cdb_value_in = 0; can_load_in = 0; flush_in = 0;
    mem_ready_in = 0; mem_rvalid_in = 0; mem_rdata_in = 0; result_grant_in = 0;

    // reset state
    #2;
    chk("rst_ready", ready_out, 1);
    chk("rst_mem_req", mem_req_out, 0);
    chk("rst_mem_addr", mem_addr_out, 0);
    chk("rst_result_valid", result_valid_out, 0);
    chk("rst_result_value", result_value_out, 0);
    chk("rst_arr_ix", 32'(lb_rob_arr_ix_out), 0);
    chk("rst_arr_dest0", lb_rob_arr_dest_out[0], 0);
    cyc();
    cyc();
    rst_in = 1'b0;
    cyc();
    $display("step: basic LW");
    load_once("lw", 3'd3, 32'h100, 32'd4, 3'd2, 32'h104, 32'hDEADBEEF, 32'hDEADBEEF);
    chk("lw_free_after_grant_ix", lb_rob_arr_ix_out[0], 0);
    chk("lw_ready_after_grant", ready_out, 1);

    $display("step: sub-word extraction");
    load_once("lb",  3'd1, 32'h200, 32'd3, 3'd0, 32'h203, 32'h80FFFFFF, 32'hFFFFFF80);
    load_once("lbu", 3'd1, 32'h200, 32'd3, 3'd4, 32'h203, 32'h80FFFFFF, 32'h00000080);
    load_once("lh",  3'd2, 32'h200, 32'd2, 3'd1, 32'h202, 32'h80011234, 32'hFFFF8001);
    load_once("lhu", 3'd2, 32'h200, 32'd0, 3'd5, 32'h200, 32'h0000F234, 32'h0000F234);
    load_once("lb_pos", 3'd4, 32'h200, 32'd1, 3'd0, 32'h201, 32'h00007F00, 32'h0000007F);
    load_once("neg_imm", 3'd5, 32'h100, 32'hFFFFFFFC, 3'd2, 32'h0FC, 32'h12345678, 32'h12345678);

    $display("step: base wakeup in issue cycle");
    can_load_in = 3'b000;
    set_load(3'd1, 1'b0, 32'h0, 3'd5, 32'd8, 3'd2);
    cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd5; cdb_value_in = 32'h40;
    cyc();
    valid_in = 1'b0; cdb_valid_in = 1'b0;
    #1;
    chk("cdb_now_dest", lb_rob_arr_dest_out[0], 32'h48);
    chk("cdb_now_no_req", mem_req_out, 0);
    cyc();
    chk("cdb_now_no_req2", mem_req_out, 0);
    finish_issue("cdb_now", 32'h48, 3'd1, 32'h11223344, 32'h11223344);
    drain_result();

    $display("step: base wakeup two cycles later");
    can_load_in = 3'b000;
    set_load(3'd2, 1'b0, 32'h0, 3'd5, 32'd8, 3'd2);
    cyc();
    valid_in = 1'b0;
    #1;
    chk("wait_base_dest", lb_rob_arr_dest_out[0], 0);
    chk("wait_base_ix", lb_rob_arr_ix_out[0], 3'd2);
    cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd6; cdb_value_in = 32'h99;
    cyc();
    cdb_valid_in = 1'b0;
    #1;
    chk("wrong_tag_dest", lb_rob_arr_dest_out[0], 0);
    cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd5; cdb_value_in = 32'h40;
    cyc();
    cdb_valid_in = 1'b0;
    #1;
    chk("cdb_late_dest", lb_rob_arr_dest_out[0], 32'h48);
    chk("cdb_late_no_req", mem_req_out, 0);
    finish_issue("cdb_late", 32'h48, 3'd2, 32'h55667788, 32'h55667788);
    drain_result();

    $display("step: fill buffer");
    can_load_in = 3'b000;
    set_load(3'd1, 1'b1, 32'h400, 3'd0, 32'd0, 3'd2);
    cyc();
    set_load(3'd2, 1'b1, 32'h404, 3'd0, 32'd0, 3'd2);
    cyc();
    set_load(3'd3, 1'b1, 32'h408, 3'd0, 32'd0, 3'd2);
    cyc();
    set_load(3'd4, 1'b1, 32'h40C, 3'd0, 32'd0, 3'd2);
    #1;
    chk("full_ready", ready_out, 0);
    cyc();
    valid_in = 1'b0;
    #1;
    chk("full_ix0", lb_rob_arr_ix_out[0], 3'd1);
    chk("full_ix1", lb_rob_arr_ix_out[1], 3'd2);
    chk("full_ix2", lb_rob_arr_ix_out[2], 3'd3);
    chk("full_dest2", lb_rob_arr_dest_out[2], 32'h408);
    can_load_in = 3'b001;
    mem_ready_in = 1'b1;
    #1;
    chk("full_addr", mem_addr_out, 32'h400);
    cyc();
    mem_ready_in = 1'b0;
    sb_q.push_back('{ix: 3'd1, val: 32'hA5A50001});
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'hA5A50001;
    cyc();
    mem_rvalid_in = 1'b0;
    #1;
    wait_result();
    chk("full_ready_before_grant", ready_out, 0);
    result_grant_in = 1'b1;
    set_load(3'd5, 1'b1, 32'h500, 3'd0, 32'd0, 3'd2);
    cyc();
    result_grant_in = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("grant_ready_next", ready_out, 1);
    chk("grant_slot_not_reused", lb_rob_arr_ix_out[0], 0);
    flush_in = 1'b1;
    cyc();
    flush_in = 1'b0;
    #1;
    chk("flush_idle_ready", ready_out, 1);
    chk("flush_idle_ix", 32'(lb_rob_arr_ix_out), 0);

    $display("step: flush with issued request");
    set_load(3'd2, 1'b1, 32'h500, 3'd0, 32'd0, 3'd2);
    cyc();
    valid_in = 1'b0;
    can_load_in = 3'b111; mem_ready_in = 1'b1;
    cyc();
    mem_ready_in = 1'b0;
    flush_in = 1'b1;
    cyc();
    flush_in = 1'b0;
    #1;
    chk("flush_ready", ready_out, 1);
    chk("flush_ix", 32'(lb_rob_arr_ix_out), 0);
    chk("flush_no_req", mem_req_out, 0);
    set_load(3'd4, 1'b1, 32'h600, 3'd0, 32'd0, 3'd2);
    cyc();
    valid_in = 1'b0;
    #1;
    chk("discard_dest", lb_rob_arr_dest_out[0], 32'h600);
    chk("discard_blocks_req", mem_req_out, 0);
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'hBAD0BAD0;
    cyc();
    mem_rvalid_in = 1'b0;
    #1;
    chk("discard_no_result", result_valid_out, 0);
    finish_issue("after_discard", 32'h600, 3'd4, 32'h0BADF00D, 32'h0BADF00D);
    drain_result();

    $display("step: two eligible entries, stalled memory");
    can_load_in = 3'b101; mem_ready_in = 1'b0;
    set_load(3'd1, 1'b1, 32'h300, 3'd0, 32'd0, 3'd2);
    cyc();
    set_load(3'd2, 1'b1, 32'h310, 3'd0, 32'd0, 3'd2);
    cyc();
    set_load(3'd3, 1'b1, 32'h320, 3'd0, 32'd0, 3'd2);
    cyc();
    valid_in = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_req", mem_req_out, 1);
      chk("stall_addr", mem_addr_out, 32'h300);
      cyc();
    end
    mem_ready_in = 1'b1;
    cyc();
    chk("one_outstanding", mem_req_out, 0);
    cyc();
    chk("one_outstanding2", mem_req_out, 0);
    mem_ready_in = 1'b0;
    sb_q.push_back('{ix: 3'd1, val: 32'h01010101});
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'h01010101;
    #1;
    chk("no_req_during_rvalid", mem_req_out, 0);
    cyc();
    mem_rvalid_in = 1'b0;
    #1;
    chk("second_req", mem_req_out, 1);
    chk("second_addr", mem_addr_out, 32'h320);
    mem_ready_in = 1'b1;
    cyc();
    mem_ready_in = 1'b0;
    sb_q.push_back('{ix: 3'd3, val: 32'h03030303});
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'h03030303;
    cyc();
    mem_rvalid_in = 1'b0;
    #1;
    drain_result();
    drain_result();
    chk("blocked_entry_ix", lb_rob_arr_ix_out[1], 3'd2);
    flush_in = 1'b1;
    cyc();
    flush_in = 1'b0;

    $display("step: reset mid-transaction");
    set_load(3'd6, 1'b1, 32'h700, 3'd0, 32'd0, 3'd2);
    cyc();
    valid_in = 1'b0;
    can_load_in = 3'b111; mem_ready_in = 1'b1;
    cyc();
    mem_ready_in = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("arst_ready", ready_out, 1);
    chk("arst_ix", 32'(lb_rob_arr_ix_out), 0);
    chk("arst_mem_req", mem_req_out, 0);
    rst_in = 1'b0;
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'hCAFECAFE;
    cyc();
    mem_rvalid_in = 1'b0;
    #1;
    chk("arst_stale_rvalid", result_valid_out, 0);
    load_once("post_rst", 3'd7, 32'h700, 32'h10, 3'd5, 32'h710, 32'h87654321, 32'h00004321);

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_buffer.md
LOAD_BUFFER -- requirements
Module: load_buffer

Interface
REQ-001 The block SHALL have parameter LOAD_BUFFER_DEPTH, default 3, giving the number of load entries.
REQ-002 The block SHALL have parameter ROB_SIZE, default 8, giving the ROB depth; ROB_IX = $clog2(ROB_SIZE)-1.
REQ-003 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 valid_in  input  1  issue a load this cycle.
REQ-006 rob_ix_in  input  ROB_IX+1  ROB tag of the issued load.
REQ-007 base_ready_in, base_value_in[31:0] signed, base_tag_in[ROB_IX:0]  inputs  base operand: either its value, or the ROB tag that will produce it.
REQ-008 imm_in  input  32 signed  address offset; funct3_in  input  3  load width (LB=0, LH=1, LW=2, LBU=4, LHU=5).
REQ-009 cdb_valid_in, cdb_rob_ix_in[ROB_IX:0], cdb_value_in[31:0]  inputs  CDB broadcast.
REQ-010 can_load_in  input  LOAD_BUFFER_DEPTH  per-entry store-ordering clearance from the ROB.
REQ-011 flush_in  input  1  branch-mispredict flush.
REQ-012 mem_ready_in, mem_rvalid_in  input  1 each; mem_rdata_in  input  32  word data-memory port.
REQ-013 result_grant_in  input  1  CDB arbiter accepts the presented result.
REQ-014 ready_out  output  1  at least one free entry.
REQ-015 lb_rob_arr_ix_out  output  [LOAD_BUFFER_DEPTH-1:0] array of ROB_IX+1  per-entry ROB tag, sent to the ROB.
REQ-016 lb_rob_arr_dest_out  output  [LOAD_BUFFER_DEPTH-1:0] array of 32 signed  per-entry effective address, sent to the ROB.
REQ-017 mem_req_out  output  1; mem_addr_out  output  32  byte address of the memory request.
REQ-018 result_valid_out  output  1; result_rob_ix_out  output  ROB_IX+1; result_value_out  output  32  CDB result.

Function
REQ-019 Each entry SHALL be in one of five states: FREE, WAIT_BASE, WAIT_ORDER, ISSUED, DONE.
REQ-020 Allocation: when valid_in && ready_out, the lowest-index FREE entry SHALL be loaded on the next edge; valid_in while !ready_out SHALL be ignored.
REQ-021 If base_ready_in, or a CDB tag match (cdb_valid_in && cdb_rob_ix_in==base_tag_in) occurs in the issue cycle, the entry SHALL enter WAIT_ORDER; otherwise it SHALL enter WAIT_BASE.
REQ-022 On entry to WAIT_ORDER: addr = base + imm_in (32-bit wrap). The base is base_value_in if ready, else cdb_value_in.
REQ-023 WAIT_BASE -> WAIT_ORDER SHALL occur on the edge of the cycle in which the CDB broadcasts the entry's base tag.
REQ-024 Ordering: an entry in WAIT_ORDER is eligible when can_load_in[i]=1; can_load_in[i] SHALL be ignored in every other state.
REQ-025 Memory issue: one request may be outstanding at a time.
REQ-026 When no entry is ISSUED, mem_req_out SHALL be asserted combinationally for the lowest-index eligible entry, with mem_addr_out = its addr.
REQ-027 Issue handshake: on the edge with mem_req_out && mem_ready_in, that entry SHALL go to ISSUED; without mem_ready_in it SHALL stay and keep requesting.
REQ-028 On mem_rvalid_in, the ISSUED entry SHALL capture the extracted value and go to DONE.
REQ-029 Byte lane = addr[1:0]; halfword lane = addr[1].
REQ-030 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; misalignment is not checked.
REQ-031 result_valid_out SHALL be asserted while any entry is DONE, presenting the lowest-index DONE entry; it SHALL hold stable until result_grant_in.
REQ-032 On the edge with result_valid_out && result_grant_in, that entry SHALL return to FREE.
REQ-033 FREE entries SHALL drive lb_rob_arr_ix_out=0 and lb_rob_arr_dest_out=0; WAIT_BASE entries SHALL drive dest 0.
REQ-034 ready_out = any entry FREE, combinational.
REQ-035 Flush: flush_in SHALL force every entry to FREE on the next edge, with priority over allocation, wakeup and grant in the same cycle.
REQ-036 Flush with a request ISSUED: the block SHALL set a discard flag and drop the next mem_rvalid_in; mem_req_out SHALL stay 0 until that response arrives.
REQ-037 A slot freed by grant SHALL not be reallocated in the same cycle; it SHALL be available from the next cycle.

Reset
REQ-038 On rst_in, asynchronously, all entries SHALL go FREE and the discard flag SHALL clear.
REQ-039 During and after reset: ready_out=1; mem_req_out, result_valid_out, mem_addr_out, result_rob_ix_out, result_value_out and all array outputs = 0.
REQ-040 rst_in asserted mid-transaction SHALL abandon the outstanding request; a later mem_rvalid_in with no ISSUED entry SHALL be ignored.

Verification
REQ-041 LW, base ready 0x100, imm 4, tag 3, can_load=1, mem_ready=1, rdata 0xDEADBEEF one cycle later -> mem_addr_out=0x104, then result_valid_out with ix 3 and value 0xDEADBEEF; entry FREE after grant.
REQ-042 LB, addr 0x203, rdata 0x80FF_FFFF -> 0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-043 Base waits on tag 5; CDB tag 5 value 0x40 in the issue cycle and, separately, 2 cycles later -> dest 0x40+imm in both cases, and no memory request while can_load=0.
REQ-044 Three loads fill the buffer -> ready_out=0 and a fourth valid_in is ignored; after one grant, ready_out=1 on the next cycle.
REQ-045 Flush while a request is ISSUED -> all entries FREE, the following rvalid is discarded, and no result_valid_out follows.
REQ-046 Two eligible entries (0 and 2) with mem_ready low for 3 cycles -> entry 0 is requested with a stable address; entry 2 issues only after entry 0's response.
